// File: rtl/data_mem_line_store_if.sv
// Line-transfer bus between the D-cache (master) and its backing line store (slave),
// plus the SDU debug read port.
interface data_mem_line_store_if #(
  parameter int MEM_ADDR_LEN  = 8,
  parameter int LINEWORD_SIZE = 4
);
  logic                          wr_req;
  logic                          rd_req;
  logic [MEM_ADDR_LEN-1:0]       mem_addr;
  logic [32*LINEWORD_SIZE-1:0]   CacheToMem_wr_line;
  logic [32*LINEWORD_SIZE-1:0]   MemToCache_rd_line;
  logic                          handshake;
  logic [31:0]                   addr_sdu;
  logic [31:0]                   data_sdu;

  modport master (
    output wr_req, rd_req, mem_addr, CacheToMem_wr_line, addr_sdu,
    input  MemToCache_rd_line, handshake, data_sdu
  );

  modport slave (
    input  wr_req, rd_req, mem_addr, CacheToMem_wr_line, addr_sdu,
    output MemToCache_rd_line, handshake, data_sdu
  );
endinterface

// File: rtl/data_mem_line_store.sv
// Backing line store for the two-way write-back D-cache.
// Whole-line refills and evictions complete LATENCY edges after acceptance and are
// acknowledged with a one-cycle handshake; the SDU gets a combinational word read.
module data_mem_line_store #(
  parameter int TAG_LEN           = 3,
  parameter int INDEX_ADDR_LEN    = 5,
  parameter int LINEWORD_ADDR_LEN = 2,
  parameter int LATENCY           = 4
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_line_store_if.slave bus
);
  localparam int MEM_ADDR_LEN  = TAG_LEN + INDEX_ADDR_LEN;
  localparam int LINEWORD_SIZE = 1 << LINEWORD_ADDR_LEN;
  localparam int WORD_ADDR_LEN = MEM_ADDR_LEN + LINEWORD_ADDR_LEN;
  localparam int MEM_WORDS     = 1 << WORD_ADDR_LEN;
  localparam int CNT_W         = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic                        accept;
  logic                        complete;
  logic                        op_wr;
  logic [MEM_ADDR_LEN-1:0]     line_addr;
  logic                        handshake_q;
  logic [32*LINEWORD_SIZE-1:0] rd_line_q;
  logic [32*LINEWORD_SIZE-1:0] stored_line;
  logic                        unused_addr_bits;

  // Storage powers up cleared and is deliberately left untouched by rst.
  logic [31:0] storage [MEM_WORDS] = '{default: '0};

  // Next-state logic: accept only when idle and not in the handshake cycle, so the
  // requester's still-high request during handshake is not mistaken for a new one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if ((bus.wr_req || bus.rd_req) && !handshake_q) begin
          accept     = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(LATENCY)) begin
          complete   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch, handshake pulse and registered read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      handshake_q <= 1'b0;
      rd_line_q   <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      handshake_q <= complete;
      if (accept) begin
        op_wr     <= bus.wr_req;
        line_addr <= bus.mem_addr;
      end
      if (complete && !op_wr) begin
        rd_line_q <= stored_line;
      end
    end
  end

  // Eviction write: the line is taken from the bus at the completion edge, not at acceptance.
  always_ff @(posedge clk) begin
    if (!rst && complete && op_wr) begin
      for (int j = 0; j < LINEWORD_SIZE; j++) begin
        storage[{line_addr, LINEWORD_ADDR_LEN'(j)}] <= bus.CacheToMem_wr_line[32*j +: 32];
      end
    end
  end

  // Gather the latched line's words, word j into bits [32j+31:32j].
  always_comb begin
    stored_line = '0;
    for (int j = 0; j < LINEWORD_SIZE; j++) begin
      stored_line[32*j +: 32] = storage[{line_addr, LINEWORD_ADDR_LEN'(j)}];
    end
  end

  assign bus.MemToCache_rd_line = rd_line_q;
  assign bus.handshake          = handshake_q;
  assign bus.data_sdu           = storage[bus.addr_sdu[WORD_ADDR_LEN+1:2]];
  assign unused_addr_bits       = ^{bus.addr_sdu[31:WORD_ADDR_LEN+2], bus.addr_sdu[1:0]};
endmodule

// File: tb/tb_data_mem_line_store.sv
// Self-checking bench for data_mem_line_store: directed scenarios plus randomized
// transactions, compared every cycle against a transaction-level model.
module tb_data_mem_line_store;
  localparam int LATENCY = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks    = 0;
  int   failures  = 0;
  int   hs_count  = 0;

  data_mem_line_store_if #(.MEM_ADDR_LEN(8), .LINEWORD_SIZE(4)) bus ();

  data_mem_line_store #(
    .TAG_LEN(3), .INDEX_ADDR_LEN(5), .LINEWORD_ADDR_LEN(2), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model state: word array plus the edge number of the pending transfer.
  logic [31:0]  model_mem [1024];
  logic [127:0] exp_rd     = '0;
  logic         exp_hs     = 1'b0;
  bit           model_live = 1'b0;
  bit           pending    = 1'b0;
  bit           pend_wr;
  logic [7:0]   pend_addr;
  longint       edge_no     = 0;
  longint       accept_edge = 0;
  longint       done_edge   = -10;

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Model: a transfer accepted at edge n completes at edge n+LATENCY; nothing is
  // accepted at the edge right after a completion (handshake cycle).
  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      pending    = 1'b0;
      exp_hs     = 1'b0;
      exp_rd     = '0;
      done_edge  = -10;
      model_live = 1'b1;
    end else begin
      exp_hs = 1'b0;
      if (pending && edge_no == accept_edge + LATENCY) begin
        for (int j = 0; j < 4; j++) begin
          if (pend_wr) model_mem[int'(pend_addr) * 4 + j] = bus.CacheToMem_wr_line[32*j +: 32];
          else         exp_rd[32*j +: 32] = model_mem[int'(pend_addr) * 4 + j];
        end
        exp_hs    = 1'b1;
        pending   = 1'b0;
        done_edge = edge_no;
      end else if (!pending && (bus.wr_req || bus.rd_req) && edge_no != done_edge + 1) begin
        pending     = 1'b1;
        accept_edge = edge_no;
        pend_wr     = bus.wr_req;
        pend_addr   = bus.mem_addr;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_live) begin
      if (bus.handshake === 1'b1) hs_count++;
      checkOutput("handshake", 128'(bus.handshake), 128'(exp_hs));
      checkOutput("rd_line", bus.MemToCache_rd_line, exp_rd);
      checkOutput("data_sdu", 128'(bus.data_sdu), 128'(model_mem[bus.addr_sdu[11:2]]));
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Counts idle negedges until handshake is seen; the first counted one precedes acceptance.
  task automatic waitHandshake(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.handshake) break;
      waited++;
      if (waited > LATENCY + 20) begin
        checkOutput("handshake_timeout", 128'(0), 128'(1));
        break;
      end
    end
  endtask

  // One requester transaction; drops the request after handshake unless keep is set.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] addr,
                               input logic [127:0] line, input bit churn,
                               input bit early_drop, input bit keep, output int waited);
    bus.wr_req             = wr;
    bus.rd_req             = rd;
    bus.mem_addr           = addr;
    bus.CacheToMem_wr_line = line;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.handshake) break;
      waited++;
      if (waited > LATENCY + 20) begin
        checkOutput("handshake_timeout", 128'(0), 128'(1));
        break;
      end
      if (churn && waited >= 2) begin
        bus.mem_addr           = 8'($urandom);
        bus.CacheToMem_wr_line = {$urandom, $urandom, $urandom, $urandom};
      end
      if (early_drop && waited == 3) begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    if (!keep) begin
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
    end
  endtask

  // Hard stop in case something above never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] line2, line3, line4, line6, held;
    logic [7:0]   pool [6];
    int           w, gap, hs_before, pick;
    bit           do_wr, do_rd;

    line2 = {32'h4, 32'h3, 32'h2, 32'h1};
    line3 = {32'hA3A3_0003, 32'hA3A3_0002, 32'hA3A3_0001, 32'hA3A3_0000};
    line4 = {32'h1010_0004, 32'h1010_0003, 32'h1010_0002, 32'h1010_0001};
    line6 = {32'hFFFF_DDDD, 32'hFFFF_CCCC, 32'hFFFF_BBBB, 32'hFFFF_AAAA};
    pool  = '{8'h00, 8'h05, 8'h10, 8'h7F, 8'hA3, 8'hFF};

    rst                    = 1'b1;
    bus.wr_req             = 1'b0;
    bus.rd_req             = 1'b0;
    bus.mem_addr           = '0;
    bus.CacheToMem_wr_line = '0;
    bus.addr_sdu           = '0;
    repeat (3) stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("reset_handshake", 128'(bus.handshake), 128'(0));
    checkOutput("reset_rd_line", bus.MemToCache_rd_line, 128'(0));

    // Read of never-written line 0x05 returns zero after LATENCY.
    applyStimulus(1'b0, 1'b1, 8'h05, '0, 1'b0, 1'b0, 1'b0, w);
    checkOutput("t1_latency", 128'(w), 128'(LATENCY + 1));
    checkOutput("t1_rd_line", bus.MemToCache_rd_line, 128'(0));
    checkOutput("t1_handshake_one_cycle", 128'(bus.handshake), 128'(0));

    // Write line 0x05 and read words back through the debug port.
    applyStimulus(1'b1, 1'b0, 8'h05, line2, 1'b0, 1'b0, 1'b0, w);
    checkOutput("t2_latency", 128'(w), 128'(LATENCY + 1));
    bus.addr_sdu = 32'h50;
    #1;
    checkOutput("t2_sdu_0x50", 128'(bus.data_sdu), 128'(32'h1));
    bus.addr_sdu = 32'h5C;
    #1;
    checkOutput("t2_sdu_0x5C", 128'(bus.data_sdu), 128'(32'h4));

    // Write 0xA3 then read it back starting the cycle after handshake.
    hs_before = hs_count;
    applyStimulus(1'b1, 1'b0, 8'hA3, line3, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(1'b0, 1'b1, 8'hA3, 128'(0), 1'b0, 1'b0, 1'b0, w);
    checkOutput("t3_read_latency", 128'(w), 128'(LATENCY + 1));
    checkOutput("t3_rd_line", bus.MemToCache_rd_line, line3);
    checkOutput("t3_pulses", 128'(hs_count - hs_before), 128'(2));

    // Both requests high: write wins; sustained request re-accepted only after handshake.
    applyStimulus(1'b1, 1'b1, 8'h10, line4, 1'b0, 1'b0, 1'b1, w);
    waitHandshake(gap);
    checkOutput("t4_sustained_gap", 128'(gap), 128'(LATENCY + 1));
    stepCycle();
    bus.wr_req   = 1'b0;
    bus.rd_req   = 1'b0;
    bus.addr_sdu = 32'h10C;
    #1;
    checkOutput("t4_rd_line_unchanged", bus.MemToCache_rd_line, line3);
    checkOutput("t4_sdu_word3", 128'(bus.data_sdu), 128'(32'h1010_0004));

    // Reset two cycles into a write to 0x20 aborts it.
    bus.addr_sdu           = 32'h200;
    bus.wr_req             = 1'b1;
    bus.mem_addr           = 8'h20;
    bus.CacheToMem_wr_line = {4{32'hBAD0_0BAD}};
    stepCycle();
    stepCycle();
    rst        = 1'b1;
    bus.wr_req = 1'b0;
    hs_before  = hs_count;
    stepCycle();
    rst = 1'b0;
    repeat (LATENCY + 3) stepCycle();
    checkOutput("t5_no_handshake", 128'(hs_count - hs_before), 128'(0));
    checkOutput("t5_handshake", 128'(bus.handshake), 128'(0));
    checkOutput("t5_rd_line", bus.MemToCache_rd_line, 128'(0));
    checkOutput("t5_line_unchanged", 128'(bus.data_sdu), 128'(0));

    // Top line 0xFF: write, read, then rd_line must hold for three idle cycles.
    applyStimulus(1'b1, 1'b0, 8'hFF, line6, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(1'b0, 1'b1, 8'hFF, 128'(0), 1'b0, 1'b0, 1'b0, w);
    checkOutput("t6_rd_line", bus.MemToCache_rd_line, line6);
    held = bus.MemToCache_rd_line;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("t6_rd_hold", bus.MemToCache_rd_line, line6);
    end
    checkOutput("t6_rd_hold_same", bus.MemToCache_rd_line, held);

    // Randomized traffic over a small address pool so reads often hit written lines.
    for (int n = 0; n < 150; n++) begin
      pick  = $urandom_range(0, 3);
      do_wr = (pick != 2);
      do_rd = (pick >= 2);
      bus.addr_sdu = {20'($urandom), pool[$urandom_range(0, 5)], 2'($urandom), 2'($urandom)};
      applyStimulus(do_wr, do_rd, pool[$urandom_range(0, 5)],
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 1'b0, w);
      checkOutput("rand_latency", 128'(w), 128'(LATENCY + 1));
      repeat ($urandom_range(0, 2)) begin
        bus.addr_sdu = {20'($urandom), pool[$urandom_range(0, 5)], 2'($urandom), 2'($urandom)};
        stepCycle();
      end
    end

    stepCycle();
    $display("[TB] stimulus complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
